// File: rtl/sw_debounce_toggle.sv
// sw_debounce_toggle: per-channel synchronise, debounce, press/release pulses and LED toggle/follow for active-low switches.
module sw_debounce_toggle #(
    parameter int CHANNELS    = 4,
    parameter int DIV_BITS    = 15,
    parameter int DEB_SAMPLES = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] sw_in_n,
    input  logic [CHANNELS-1:0] mode,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] rel_pulse,
    output logic [CHANNELS-1:0] pressed,
    output logic [CHANNELS-1:0] led_out,
    output logic                tick
);
    logic [CHANNELS-1:0] sync_a, sync_n, sample, accept;
    logic [DIV_BITS-1:0] div;
    logic [7:0]          count [CHANNELS];

    // accept: the DEB_SAMPLES-th consecutive differing sample arrives on this tick
    always_comb begin
        sample = ~sync_n;
        accept = '0;
        for (int c = 0; c < CHANNELS; c++)
            accept[c] = tick && (sample[c] != pressed[c]) && (count[c] == 8'(DEB_SAMPLES - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a      <= '1;
            sync_n      <= '1;
            div         <= '0;
            tick        <= 1'b0;
            pressed     <= '0;
            press_pulse <= '0;
            rel_pulse   <= '0;
            led_out     <= '0;
            for (int c = 0; c < CHANNELS; c++)
                count[c] <= 8'd0;
        end else begin
            sync_a      <= sw_in_n;
            sync_n      <= sync_a;
            div         <= div + 1'b1;
            tick        <= &div;
            pressed     <= pressed ^ accept;
            press_pulse <= accept & sample;
            rel_pulse   <= accept & ~sample;
            for (int c = 0; c < CHANNELS; c++) begin
                if (tick)
                    count[c] <= (sample[c] == pressed[c] || accept[c]) ? 8'd0 : count[c] + 8'd1;
                led_out[c] <= mode[c] ? pressed[c] : led_out[c] ^ (accept[c] & sample[c]);
            end
        end
    end
endmodule
